// File: rtl/test_supervisor.sv
// Test supervisor: resets a program-running DUT, times each run, and reports
// pass/timeout over RUNS back-to-back runs per start pulse.
module test_supervisor #(
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 1000,
   parameter int unsigned RUNS         = 1,
   parameter int unsigned CW           = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          dut_finished,
   input  logic          dut_success,
   output logic          dut_reset,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          timed_out,
   output logic [CW-1:0] cycles,
   output logic [7:0]    run_index
);

   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [7:0]    HOLD_LAST = 8'(RESET_CYCLES - 1);
   localparam logic [7:0]    RUNS_C    = 8'(RUNS);

   typedef enum logic [2:0] {IDLE, HOLD, RUN, CHECK, DONE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    hold_cnt, hold_cnt_nxt;
   logic [CW-1:0] run_cnt, run_cnt_nxt;
   logic          run_ok, run_ok_nxt;
   logic          pass_nxt, timed_out_nxt;
   logic [CW-1:0] cycles_nxt;
   logic [7:0]    run_index_nxt;
   logic [CW-1:0] count_c;
   logic [7:0]    index_inc_c;

   // count_c is the RUN-cycle count including the current cycle
   assign count_c     = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CW'(1);
   assign index_inc_c = run_index + 8'd1;

   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      run_cnt_nxt   = run_cnt;
      run_ok_nxt    = run_ok;
      pass_nxt      = pass;
      timed_out_nxt = timed_out;
      cycles_nxt    = cycles;
      run_index_nxt = run_index;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt     = HOLD;
               hold_cnt_nxt  = 8'd0;
               pass_nxt      = 1'b1;
               timed_out_nxt = 1'b0;
               run_index_nxt = 8'd0;
               cycles_nxt    = '0;
            end
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nxt   = RUN;
               run_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         RUN: begin
            run_cnt_nxt = count_c;
            // finish wins over timeout when both land on the same cycle
            if (dut_finished) begin
               state_nxt  = CHECK;
               cycles_nxt = count_c;
               run_ok_nxt = dut_success;
            end else if (count_c == TIMEOUT_C) begin
               state_nxt     = CHECK;
               cycles_nxt    = count_c;
               run_ok_nxt    = 1'b0;
               timed_out_nxt = 1'b1;
            end
         end
         CHECK: begin
            pass_nxt      = pass & run_ok;
            run_index_nxt = index_inc_c;
            if (timed_out || index_inc_c >= RUNS_C) begin
               state_nxt = DONE;
            end else begin
               state_nxt    = HOLD;
               hold_cnt_nxt = 8'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hold_cnt  <= 8'd0;
         run_cnt   <= '0;
         run_ok    <= 1'b0;
         pass      <= 1'b0;
         timed_out <= 1'b0;
         cycles    <= '0;
         run_index <= 8'd0;
         dut_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         run_cnt   <= run_cnt_nxt;
         run_ok    <= run_ok_nxt;
         pass      <= pass_nxt;
         timed_out <= timed_out_nxt;
         cycles    <= cycles_nxt;
         run_index <= run_index_nxt;
         dut_reset <= (state_nxt == IDLE) || (state_nxt == HOLD) || (state_nxt == DONE);
         busy      <= (state_nxt == HOLD) || (state_nxt == RUN) || (state_nxt == CHECK);
         done      <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_test_supervisor.sv
// Bench for test_supervisor: two instances (RUNS=1 and RUNS=3), a bench-side
// DUT emulator, and a per-instance scoreboard popped on each rising done.
module tb_test_supervisor;

   localparam int unsigned RC = 4;
   localparam int unsigned TO = 20;

   typedef struct packed {
      logic        pass;
      logic        timed_out;
      logic [15:0] cycles;
      logic [7:0]  run_index;
   } res_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_s   [2];
   logic        fin_s     [2];
   logic        suc_s     [2];
   logic        dut_reset_s [2];
   logic        busy_s    [2];
   logic        done_s    [2];
   logic        pass_s    [2];
   logic        to_s      [2];
   logic [15:0] cycles_s  [2];
   logic [7:0]  idx_s     [2];

   int   n_cmp = 0;
   int   n_err = 0;
   res_t exp_q0 [$];
   res_t exp_q1 [$];
   res_t got0, got1;
   logic done_q0 = 1'b0;
   logic done_q1 = 1'b0;
   int   hold_len = 0;

   always #5 clock = ~clock;

   test_supervisor #(.RESET_CYCLES(RC), .TIMEOUT(TO), .RUNS(1), .CW(16)) dut_a (
      .clock(clock), .reset(reset), .start(start_s[0]),
      .dut_finished(fin_s[0]), .dut_success(suc_s[0]),
      .dut_reset(dut_reset_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .pass(pass_s[0]), .timed_out(to_s[0]), .cycles(cycles_s[0]), .run_index(idx_s[0]));

   test_supervisor #(.RESET_CYCLES(RC), .TIMEOUT(TO), .RUNS(3), .CW(16)) dut_b (
      .clock(clock), .reset(reset), .start(start_s[1]),
      .dut_finished(fin_s[1]), .dut_success(suc_s[1]),
      .dut_reset(dut_reset_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .pass(pass_s[1]), .timed_out(to_s[1]), .cycles(cycles_s[1]), .run_index(idx_s[1]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // scoreboard monitors: compare on each rising done
   always @(negedge clock) begin
      if (done_s[0] && !done_q0) begin
         got0 = '{pass_s[0], to_s[0], cycles_s[0], idx_s[0]};
         if (exp_q0.size() == 0) bound_fail("result_a_unexpected");
         else check("result_a {pass,to,cycles,idx}", 64'(got0), 64'(exp_q0.pop_front()));
      end
      done_q0 <= done_s[0];
   end

   always @(negedge clock) begin
      if (done_s[1] && !done_q1) begin
         got1 = '{pass_s[1], to_s[1], cycles_s[1], idx_s[1]};
         if (exp_q1.size() == 0) bound_fail("result_b_unexpected");
         else check("result_b {pass,to,cycles,idx}", 64'(got1), 64'(exp_q1.pop_front()));
      end
      done_q1 <= done_s[1];
   end

   // dut_reset high-time per run on instance B
   always @(negedge clock) begin
      if (busy_s[1] && dut_reset_s[1]) begin
         hold_len <= hold_len + 1;
      end else if (hold_len != 0) begin
         check("hold_len_b", 64'(hold_len), 64'(RC));
         hold_len <= 0;
      end
   end

   task automatic push(input int d, input logic p, input logic t, input int cyc, input int idx);
      res_t e;
      e = '{p, t, 16'(cyc), 8'(idx)};
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   task automatic pulse_start(input int d);
      start_s[d] = 1'b1;
      @(negedge clock);
      start_s[d] = 1'b0;
   endtask

   task automatic wait_rst(input int d, input logic lvl);
      int i;
      i = 0;
      while (dut_reset_s[d] !== lvl && i < 300) begin
         @(negedge clock);
         i++;
      end
      if (dut_reset_s[d] !== lvl) bound_fail("wait_dut_reset");
   endtask

   task automatic wait_done(input int d);
      int i;
      i = 0;
      while (done_s[d] !== 1'b1 && i < 300) begin
         @(negedge clock);
         i++;
      end
      if (done_s[d] !== 1'b1) bound_fail("wait_done");
      @(negedge clock);
   endtask

   // emulate a DUT finishing in RUN cycle n; optionally poke start while busy
   task automatic run_dut(input int d, input int n, input logic suc, input logic poke);
      int waits;
      wait_rst(d, 1'b1);
      wait_rst(d, 1'b0);
      waits = n - 1;
      if (poke) begin
         pulse_start(d);
         check("start_ignored {dut_reset,busy,idx}",
               64'({dut_reset_s[d], busy_s[d], idx_s[d]}), 64'({1'b0, 1'b1, 8'd1}));
         waits = waits - 1;
      end
      repeat (waits) @(negedge clock);
      fin_s[d] = 1'b1;
      suc_s[d] = suc;
      @(negedge clock);
      fin_s[d] = 1'b0;
      suc_s[d] = 1'b0;
   endtask

   task automatic check_reset_vals(input int d, input string name);
      check(name, 64'({dut_reset_s[d], busy_s[d], done_s[d], pass_s[d], to_s[d], cycles_s[d], idx_s[d]}),
            64'({1'b1, 4'b0000, 16'd0, 8'd0}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         fin_s[d]   = 1'b0;
         suc_s[d]   = 1'b0;
      end
      repeat (3) @(negedge clock);
      check_reset_vals(0, "reset_state_a");
      check_reset_vals(1, "reset_state_b");
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("idle_without_start_a", 64'({busy_s[0], done_s[0], dut_reset_s[0]}), 64'(3'b001));

      // single pass, finish after 10 RUN cycles
      push(0, 1'b1, 1'b0, 10, 1);
      pulse_start(0);
      run_dut(0, 10, 1'b1, 1'b0);
      wait_done(0);
      fin_s[0] = 1'b1;
      @(negedge clock);
      fin_s[0] = 1'b0;
      repeat (3) @(negedge clock);
      check("done_stable_a", 64'({done_s[0], pass_s[0], to_s[0], cycles_s[0], idx_s[0], dut_reset_s[0]}),
            64'({1'b1, 1'b1, 1'b0, 16'd10, 8'd1, 1'b1}));

      // timeout, DUT never finishes
      push(0, 1'b0, 1'b1, 20, 1);
      pulse_start(0);
      wait_done(0);

      // finish on the timeout cycle counts as finished
      push(0, 1'b1, 1'b0, 20, 1);
      pulse_start(0);
      run_dut(0, 20, 1'b1, 1'b0);
      wait_done(0);

      // failing run one cycle before timeout
      push(0, 1'b0, 1'b0, 19, 1);
      pulse_start(0);
      run_dut(0, 19, 1'b0, 1'b0);
      wait_done(0);

      // asynchronous reset in the middle of RUN
      pulse_start(0);
      wait_rst(0, 1'b1);
      wait_rst(0, 1'b0);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1 check_reset_vals(0, "reset_midrun_a");
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_after_reset_a", 64'({busy_s[0], done_s[0], dut_reset_s[0]}), 64'(3'b001));
      push(0, 1'b1, 1'b0, 5, 1);
      pulse_start(0);
      run_dut(0, 5, 1'b1, 1'b0);
      wait_done(0);

      // three runs, second fails, start poked while busy
      push(1, 1'b0, 1'b0, 12, 3);
      pulse_start(1);
      run_dut(1, 7, 1'b1, 1'b0);
      run_dut(1, 3, 1'b0, 1'b1);
      run_dut(1, 12, 1'b1, 1'b0);
      wait_done(1);

      // timeout in the first of three runs ends the sequence
      push(1, 1'b0, 1'b1, 20, 1);
      pulse_start(1);
      wait_done(1);

      // three passing runs: minimum latency and the timeout tie
      push(1, 1'b1, 1'b0, 20, 3);
      pulse_start(1);
      run_dut(1, 1, 1'b1, 1'b0);
      run_dut(1, 2, 1'b1, 1'b0);
      run_dut(1, 20, 1'b1, 1'b0);
      wait_done(1);

      repeat (2) @(negedge clock);
      check("pending_a", 64'(exp_q0.size()), 64'(0));
      check("pending_b", 64'(exp_q1.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/test_supervisor.md
TEST_SUPERVISOR -- requirements
Module: test_supervisor

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4: number of cycles dut_reset is held high per run, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum RUN cycles allowed per run before abort, legal range 1..2^CW-1.
REQ-003 SHALL have parameter RUNS, default 1: number of back-to-back DUT runs per start, legal range 1..255.
REQ-004 SHALL have parameter CW, default 16: width of the cycle counter.
REQ-005 SHALL have port clock, input, 1 bit: single clock for all state; every flop is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a test sequence; it is ignored unless the state is IDLE or DONE.
REQ-008 SHALL have port dut_finished, input, 1 bit: driven by the program-running block under test, high when its program ends.
REQ-009 SHALL have port dut_success, input, 1 bit: driven by the DUT; valid only while dut_finished=1.
REQ-010 SHALL have port dut_reset, output, 1 bit: restart signal to the DUT.
REQ-011 SHALL have port busy, output, 1 bit: high in states HOLD, RUN and CHECK.
REQ-012 SHALL have port done, output, 1 bit: high in state DONE.
REQ-013 SHALL have port pass, output, 1 bit: valid while done=1; high only if every run finished with dut_success=1.
REQ-014 SHALL have port timed_out, output, 1 bit: valid while done=1; high if any run reached TIMEOUT.
REQ-015 SHALL have port cycles, output, CW bits: RUN-cycle count of the most recent run.
REQ-016 SHALL have port run_index, output, 8 bits: number of runs completed so far in the current sequence.

Function
REQ-017 SHALL implement the states IDLE, HOLD, RUN, CHECK and DONE, with IDLE as the reset state.
REQ-018 SHALL, on start in IDLE or DONE, move to HOLD and clear pass-accumulator to 1, timed_out to 0, run_index to 0 and cycles to 0.
REQ-019 SHALL, in HOLD, drive dut_reset=1 for exactly RESET_CYCLES cycles, then enter RUN with dut_reset=0 and the cycle counter cleared.
REQ-020 SHALL, in RUN, increment the cycle counter by 1 each cycle, saturating at 2^CW-1 with no wrap.
REQ-021 SHALL, in RUN, move to CHECK on the first cycle with dut_finished=1 and latch dut_success and the counter into cycles; latency is 1 clock.
REQ-022 SHALL, in RUN, move to CHECK if the counter equals TIMEOUT with dut_finished=0, setting timed_out=1 and treating the run as failed.
REQ-023 SHALL treat the run as finished, not timed out, when dut_finished=1 and counter==TIMEOUT occur in the same cycle.
REQ-024 SHALL, in CHECK, AND the run result into the pass-accumulator, increment run_index, and then go to HOLD if run_index<RUNS, else to DONE.
REQ-025 SHALL, in CHECK, go to DONE immediately after a timeout, regardless of how many runs remain.
REQ-026 SHALL keep done, pass, timed_out, cycles and run_index stable in DONE until the next start.
REQ-027 SHALL keep dut_reset=1 in IDLE and DONE, so the DUT is idle outside runs.
REQ-028 SHALL ignore start while busy=1, and ignore dut_finished and dut_success outside RUN.

Reset
REQ-029 SHALL, on reset=1 in any state including mid-run, immediately and asynchronously force state=IDLE, dut_reset=1, busy=0, done=0, pass=0, timed_out=0, cycles=0 and run_index=0.
REQ-030 SHALL leave state IDLE only on a start pulse after reset deasserts.

Verification
REQ-031 SHALL verify a single pass: with RUNS=1, pulse start and have the DUT raise finished=1, success=1 after 10 RUN cycles -> done=1, pass=1, timed_out=0, cycles=10, run_index=1.
REQ-032 SHALL verify a mid-sequence failure: with RUNS=3, make run 2 finish with success=0 -> 3 runs complete, pass=0, run_index=3.
REQ-033 SHALL verify timeout: with TIMEOUT=20 and the DUT never finishing -> done=1, timed_out=1, pass=0, cycles=20, run_index=1.
REQ-034 SHALL verify the boundary tie: with TIMEOUT=20, raise finished=1 and success=1 at count 20 -> pass=1, timed_out=0.
REQ-035 SHALL verify reset mid-operation: assert reset during RUN -> all outputs at reset values in the same cycle; a later start runs a full new sequence.
REQ-036 SHALL verify that a start pulse while busy=1 is ignored, and that dut_reset is high for exactly RESET_CYCLES cycles per run.
